// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle integer divider.
package div_pkg;

    localparam int unsigned REG_W  = 32;
    localparam int unsigned DREG_W = 64;
    localparam int unsigned ITERS  = 32;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_NOT_START        = 1'b0;
    localparam logic DIV_SIGNED           = 1'b1;
    localparam logic DIV_NOT_SIGNED       = 1'b0;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    // Two's-complement negation of a register-width value.
    function automatic logic [REG_W-1:0] negate(input logic [REG_W-1:0] v);
        return ~v + {{(REG_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider, one quotient bit per cycle, with the
// EX-stage start/ready handshake. result_o = {remainder, quotient}.
module div
    import div_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              signed_div_i,
    input  logic [REG_W-1:0]  opdata1_i,
    input  logic [REG_W-1:0]  opdata2_i,
    input  logic              start_i,
    input  logic              annul_i,
    output logic [DREG_W-1:0] result_o,
    output logic              ready_o
);

    div_state_e        state, state_n;
    logic [5:0]        cnt, cnt_n;
    logic [64:0]       dividend, dividend_n;
    logic [REG_W-1:0]  divisor, divisor_n;
    logic              neg_a, neg_a_n;
    logic              neg_b, neg_b_n;
    logic              is_signed, is_signed_n;
    logic [DREG_W-1:0] result_n;
    logic              ready_n;

    logic [REG_W:0]    diff;
    logic [REG_W-1:0]  quot, rem;
    logic [REG_W-1:0]  quot_fix, rem_fix;
    logic              op_neg_a, op_neg_b;
    logic [REG_W-1:0]  mag_a, mag_b;

    // Trial subtraction, operand magnitudes and final sign fixup.
    always_comb begin
        diff     = {1'b0, dividend[63:32]} - {1'b0, divisor};
        quot     = dividend[31:0];
        rem      = dividend[64:33];
        quot_fix = (is_signed && (neg_a ^ neg_b)) ? negate(quot) : quot;
        rem_fix  = (is_signed && neg_a) ? negate(rem) : rem;
        op_neg_a = (signed_div_i == DIV_SIGNED) && opdata1_i[REG_W-1];
        op_neg_b = (signed_div_i == DIV_SIGNED) && opdata2_i[REG_W-1];
        mag_a    = op_neg_a ? negate(opdata1_i) : opdata1_i;
        mag_b    = op_neg_b ? negate(opdata2_i) : opdata2_i;
    end

    // Next-state and next-output logic of the divide FSM.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        dividend_n  = dividend;
        divisor_n   = divisor;
        neg_a_n     = neg_a;
        neg_b_n     = neg_b;
        is_signed_n = is_signed;
        result_n    = result_o;
        ready_n     = ready_o;
        case (state)
            DIV_FREE: begin
                result_n = '0;
                ready_n  = DIV_RESULT_NOT_READY;
                if (start_i == DIV_START && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_n = DIV_BY_ZERO;
                    end else begin
                        state_n     = DIV_ON;
                        cnt_n       = '0;
                        neg_a_n     = op_neg_a;
                        neg_b_n     = op_neg_b;
                        is_signed_n = signed_div_i;
                        divisor_n   = mag_b;
                        dividend_n  = {32'b0, mag_a, 1'b0};
                    end
                end
            end
            DIV_BY_ZERO: begin
                if (annul_i) begin
                    state_n = DIV_FREE;
                end else begin
                    dividend_n = '0;
                    state_n    = DIV_END;
                    result_n   = '0;
                    ready_n    = DIV_RESULT_READY;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_n = DIV_FREE;
                    cnt_n   = '0;
                end else if (cnt != 6'(ITERS)) begin
                    if (!diff[REG_W])
                        dividend_n = {diff[31:0], dividend[31:0], 1'b1};
                    else
                        dividend_n = {dividend[63:0], 1'b0};
                    cnt_n = cnt + 6'd1;
                end else begin
                    result_n = {rem_fix, quot_fix};
                    ready_n  = DIV_RESULT_READY;
                    state_n  = DIV_END;
                    cnt_n    = '0;
                end
            end
            DIV_END: begin
                if (start_i == DIV_NOT_START) begin
                    state_n  = DIV_FREE;
                    ready_n  = DIV_RESULT_NOT_READY;
                    result_n = '0;
                end
            end
            default: state_n = DIV_FREE;
        endcase
    end

    // State, datapath and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DIV_FREE;
            cnt       <= '0;
            dividend  <= '0;
            divisor   <= '0;
            neg_a     <= 1'b0;
            neg_b     <= 1'b0;
            is_signed <= 1'b0;
            result_o  <= '0;
            ready_o   <= DIV_RESULT_NOT_READY;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            dividend  <= dividend_n;
            divisor   <= divisor_n;
            neg_a     <= neg_a_n;
            neg_b     <= neg_b_n;
            is_signed <= is_signed_n;
            result_o  <= result_n;
            ready_o   <= ready_n;
        end
    end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed handshake sequence with a result
// scoreboard filled at launch and drained when ready_o rises.
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks   = 0;
    int failures = 0;
    logic [63:0] sb[$];

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Truncating division reference: remainder takes the dividend's sign.
    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb, q, r;
        logic sa, sgb;
        if (b == 32'd0) return 64'd0;
        if (!s) return {a % b, a / b};
        sa  = a[31];
        sgb = b[31];
        ma  = sa  ? 32'd0 - a : a;
        mb  = sgb ? 32'd0 - b : b;
        q   = ma / mb;
        r   = ma % mb;
        if (sa ^ sgb) q = 32'd0 - q;
        if (sa) r = 32'd0 - r;
        return {r, q};
    endfunction

    // Cycle 0: drive a request; optionally record the expected result.
    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit push);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        if (push) sb.push_back(exp);
    endtask

    // Wait for ready_o, checking first-rise latency and the scoreboard result.
    task automatic await_ready(input string tag, input int exp_lat);
        int lat;
        logic [63:0] exp;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (ready_o) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        exp = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        check({tag, "_res"}, result_o, exp);
    endtask

    // Drop start after the result and check the handshake closes next cycle.
    task automatic release_check(input string tag);
        start_i = 1'b0;
        tick();
        check({tag, "_rdy_drop"}, 64'(ready_o), 64'd0);
        check({tag, "_res_clr"}, result_o, 64'd0);
    endtask

    task automatic full(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat);
        launch(s, a, b, exp, 1'b1);
        await_ready(tag, lat);
        release_check(tag);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        quiet;
        logic [63:0] held;

        rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
        start_i = 1'b0; annul_i = 1'b0;
        tick();
        tick();
        check("reset_rdy", 64'(ready_o), 64'd0);
        check("reset_res", result_o, 64'd0);
        rst = 1'b0;
        tick();

        // Unsigned 7/2 with start held; result held one more cycle.
        launch(1'b0, 32'd7, 32'd2, 64'h00000001_00000003, 1'b1);
        await_ready("u7_2", 34);
        held = result_o;
        tick();
        check("u7_2_hold_rdy", 64'(ready_o), 64'd1);
        check("u7_2_hold_res", result_o, held);
        release_check("u7_2");

        full("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2,         64'hFFFFFFFF_FFFFFFFD, 34);
        full("s_7_m2", 1'b1, 32'd7,        32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 34);
        full("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, 34);
        full("s_ovf",  1'b1, 32'h80000000, 32'hFFFFFFFF,  64'h00000000_80000000, 34);
        full("u_div0", 1'b0, 32'd123,      32'd0,         64'd0, 2);
        full("s_div0", 1'b1, 32'hFFFFFF00, 32'd0,         64'd0, 2);

        // Annul in cycle 10 of a division: no result ever appears.
        launch(1'b0, 32'd1000, 32'd3, 64'd0, 1'b0);
        repeat (10) tick();
        annul_i = 1'b1;
        start_i = 1'b0;
        tick();
        annul_i = 1'b0;
        quiet = 1'b1;
        repeat (40) begin
            if (ready_o !== 1'b0) quiet = 1'b0;
            tick();
        end
        check("annul_on_quiet", 64'(quiet), 64'd1);
        full("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);

        // Annul during divide-by-zero.
        launch(1'b0, 32'd5, 32'd0, 64'd0, 1'b0);
        tick();
        annul_i = 1'b1;
        start_i = 1'b0;
        tick();
        annul_i = 1'b0;
        tick();
        check("annul_dbz_rdy", 64'(ready_o), 64'd0);

        // Annul while idle suppresses start; latency counts from its release.
        launch(1'b0, 32'd9, 32'd4, 64'h00000001_00000002, 1'b1);
        annul_i = 1'b1;
        repeat (3) tick();
        check("annul_free_rdy", 64'(ready_o), 64'd0);
        annul_i = 1'b0;
        await_ready("annul_free", 34);
        // Annul has no effect once the result is presented.
        annul_i = 1'b1;
        held = result_o;
        tick();
        check("annul_end_rdy", 64'(ready_o), 64'd1);
        check("annul_end_res", result_o, held);
        annul_i = 1'b0;
        release_check("annul_end");

        // Start dropped mid-division and operands scrambled: result still completes.
        launch(1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 1'b1);
        repeat (5) tick();
        start_i = 1'b0;
        opdata1_i = 32'h12345678;
        opdata2_i = 32'd0;
        signed_div_i = 1'b0;
        await_ready("drop_mid", 29);
        tick();
        check("drop_mid_exit", 64'(ready_o), 64'd0);

        // Reset in cycle 20 of a division.
        launch(1'b0, 32'd77777, 32'd13, 64'd0, 1'b0);
        repeat (20) tick();
        rst = 1'b1;
        start_i = 1'b0;
        tick();
        check("rst_mid_rdy", 64'(ready_o), 64'd0);
        check("rst_mid_res", result_o, 64'd0);
        rst = 1'b0;
        tick();
        full("after_rst", 1'b0, 32'd7, 32'd2, 64'h00000001_00000003, 34);

        // Random operands against the reference model.
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            if (rb == 32'd0) rb = 32'd1;
            full("rand", 1'(i % 2), ra, rb, model(1'(i % 2), ra, rb), 34);
        end

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
